div_seq: RTL
============

// Module: div_seq
// PURPOSE
//   Multi-cycle iterative divider sequenced by the EX stage for DIV/DIVU.
//   EX raises start_i with both operands and holds the pipeline via stallreq_o
//   until ready_o returns {remainder, quotient} for HI/LO writeback.
//   Restoring shift-subtract, one quotient bit per clock. annul_i aborts on flush.
// PARAMETERS
//   WIDTH  32  operand width; quotient/remainder each WIDTH bits
// PORTS
//   clk           in   1        rising-edge clock
//   rst           in   1        reset, synchronous, active-high
//   signed_div_i  in   1        1 = DIV (two's complement), 0 = DIVU
//   opdata1_i     in   WIDTH    dividend (rs)
//   opdata2_i     in   WIDTH    divisor (rt)
//   start_i       in   1        request; held high by EX until ready_o seen
//   annul_i       in   1        abort current/pending division (flush)
//   result_o      out  2*WIDTH  {remainder, quotient}; valid while ready_o=1
//   ready_o       out  1        result valid
//   stallreq_o    out  1        pipeline stall request to ctrl
// BEHAVIOUR
//   - rst=1: state<=FREE, cnt<=0, result_o<=0, ready_o<=0. All outputs
//     registered except stallreq_o = start_i & ~ready_o & ~annul_i (comb).
//   - States: FREE, BYZERO, ON, END.
//   - FREE: start_i=1 & annul_i=0: latch operands and signed_div_i.
//     Divisor==0 -> BYZERO. Else -> ON, cnt<=0. Operand/mode changes after
//     latch are ignored. start_i=0 or annul_i=1: stay FREE.
//   - Operand prep (signed_div_i=1): negative operands replaced by two's-
//     complement magnitude. Unsigned: used as-is.
//   - ON: per edge, shift partial remainder left 1, bring in next dividend
//     bit MSB first, subtract divisor if non-negative, quotient bit = 1 when
//     subtracted. cnt increments. After WIDTH steps (cnt==WIDTH-1 step) -> END.
//   - BYZERO: one edge, partial results cleared to 0 -> END.
//   - END: result_o <= fixed result, ready_o <= 1 while start_i=1.
//     start_i=0: result_o<=0, ready_o<=0, -> FREE.
//   - Sign fix (signed only): quotient negated if dividend/divisor signs
//     differ; remainder takes dividend's sign. Divide-by-zero: result 0.
//   - Overflow 0x80000000 / -1 (signed): quotient 0x80000000, remainder 0;
//     no trap.
//   - Latency: counting the edge that samples start_i as edge 1, ready_o
//     rises on edge WIDTH+2 (34 for WIDTH=32). Divide-by-zero rises on edge 3.
//   - annul_i=1 in BYZERO/ON/END: next edge -> FREE, cnt<=0, result_o<=0,
//     ready_o<=0. No result is delivered for an annulled op.
//   - start_i dropped while in ON/BYZERO (without annul_i): operation completes.
//     END then sees start_i=0 and returns to FREE, so ready_o never asserts.
//   - rst mid-operation overrides all; next start begins a fresh divide.
//   - One outstanding division; start_i is not re-sampled until FREE.
// TESTING
//   - DIVU 100/7, start held -> ready_o on edge 34; result_o={32'd2,32'd14};
//     stallreq_o high edges 1-33, low once ready_o=1.
//   - DIVU 0xFFFFFFFF/0x10 -> quotient 0x0FFFFFFF, remainder 0x0000000F.
//   - DIV -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
//     DIV 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
//   - DIV 5/0 -> ready_o on edge 3, result_o=0.
//     DIV 0x80000000/0xFFFFFFFF -> {0,0x80000000}.
//   - annul_i pulse at edge 10 of a divide -> FREE next edge; ready_o stays 0.
//     A new start (9/3) then gives {0,3} on its edge 34.
//   - rst pulse at edge 20 -> all outputs 0, state FREE.
//     start_i low one cycle after ready_o -> result_o cleared, ready_o 0.

Source files
------------

// File: rtl/div_seq_if.sv
// rtl/div_seq_if.sv - EX-stage to divider handshake bundle
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic                 signed_div_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 start_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;
  logic                 stallreq_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/div_seq.sv
// rtl/div_seq.sv - restoring shift-subtract divider, one quotient bit per clock
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  div_seq_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t           state, next_state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, divisor;
  logic             neg_q, neg_r;

  logic [WIDTH:0]   shifted, diff;
  logic             ge;
  logic [WIDTH-1:0] fix_q, fix_r, mag1, mag2;
  logic             accept;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return {WIDTH{1'b0}} - x;
  endfunction

  assign accept = bus.start_i & ~bus.annul_i;
  assign mag1 = (bus.signed_div_i & bus.opdata1_i[WIDTH-1]) ? neg(bus.opdata1_i) : bus.opdata1_i;
  assign mag2 = (bus.signed_div_i & bus.opdata2_i[WIDTH-1]) ? neg(bus.opdata2_i) : bus.opdata2_i;

  // quo doubles as the dividend shift register: its MSB feeds the remainder
  // while quotient bits enter at the LSB.
  assign shifted = {rem, quo[WIDTH-1]};
  assign ge      = shifted >= {1'b0, divisor};
  assign diff    = shifted - {1'b0, divisor};
  assign fix_q   = neg_q ? neg(quo) : quo;
  assign fix_r   = neg_r ? neg(rem) : rem;

  assign bus.stallreq_o = bus.start_i & ~bus.ready_o & ~bus.annul_i;

  always_ff @(posedge clk) begin
    if (rst) state <= FREE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FREE:   if (accept) next_state = (bus.opdata2_i == '0) ? BYZERO : ON;
      BYZERO: next_state = bus.annul_i ? FREE : END;
      ON: begin
        if (bus.annul_i)     next_state = FREE;
        else if (cnt == LAST) next_state = END;
      end
      END:    if (bus.annul_i || !bus.start_i) next_state = FREE;
      default: next_state = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      rem          <= '0;
      quo          <= '0;
      divisor      <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      bus.result_o <= '0;
      bus.ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          if (accept) begin
            rem     <= '0;
            quo     <= mag1;
            divisor <= mag2;
            neg_q   <= bus.signed_div_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
            neg_r   <= bus.signed_div_i & bus.opdata1_i[WIDTH-1];
            cnt     <= '0;
          end
        end
        BYZERO: begin
          rem   <= '0;
          quo   <= '0;
          neg_q <= 1'b0;
          neg_r <= 1'b0;
          if (bus.annul_i) cnt <= '0;
        end
        ON: begin
          if (bus.annul_i) begin
            cnt <= '0;
          end else begin
            rem <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ge};
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
          end
        end
        END: begin
          if (bus.annul_i || !bus.start_i) begin
            cnt          <= '0;
            bus.result_o <= '0;
            bus.ready_o  <= 1'b0;
          end else begin
            bus.result_o <= {fix_r, fix_q};
            bus.ready_o  <= 1'b1;
          end
        end
        default: begin
          cnt          <= '0;
          bus.result_o <= '0;
          bus.ready_o  <= 1'b0;
        end
      endcase
    end
  end
endmodule
